// File: rtl/pong_pkg.sv
// pong_pkg: shared screen geometry, paddle position limits, paddle motion
// states and the player command encoding used by the paddle controller.
// Contents:
//   SCREEN_W, SCREEN_H, PADDLE_HEIGHT : screen and paddle geometry (lines)
//   POS_MAX                           : lowest legal paddle top line
//   POS_W                             : paddle position width (bits)
//   motion_e                          : IDLE / MOVE_UP / MOVE_DOWN
//   cmd_e                             : CMD_NONE / CMD_UP / CMD_DOWN
//   decode_cmd()                      : stable button pair -> cmd_e
package pong_pkg;

  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int PADDLE_HEIGHT = 50;
  localparam int POS_MAX       = SCREEN_H - PADDLE_HEIGHT;
  localparam int POS_W         = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } motion_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2
  } cmd_e;

  // Pressing both buttons cancels out, same as pressing neither.
  function automatic cmd_e decode_cmd(input logic up, input logic down);
    cmd_e cmd;
    case ({up, down})
      2'b10:   cmd = CMD_UP;
      2'b01:   cmd = CMD_DOWN;
      default: cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// paddle_axis: one player's paddle. Debounces the two synchronised buttons,
// decodes a motion command, runs the IDLE/MOVE_UP/MOVE_DOWN FSM with its
// speed register and updates the clamped paddle position on each frame tick.
// Build option: PADDLE_ACCEL_EN defined -> speed ramps by one line/frame per
// frame of continued motion up to SPEED_MAX; undefined -> constant SPEED_BASE.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   tick          : one-cycle frame strobe (vsync assertion edge)
//   btn_up_sync   : synchronised "up" button
//   btn_down_sync : synchronised "down" button
//   pos           : registered paddle top line, 0..POS_MAX_P
module paddle_axis
  import pong_pkg::*;
#(
  parameter int POS_INIT        = 215,
  parameter int POS_MAX_P       = 430,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int SPEED_BASE      = 2,
  parameter int SPEED_MAX       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn_up_sync,
  input  logic             btn_down_sync,
  output logic [POS_W-1:0] pos
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SPD_W = $clog2(SPEED_MAX + 2);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SPD_W-1:0] SPD_BASE  = SPD_W'(SPEED_BASE);
`ifdef PADDLE_ACCEL_EN
  localparam logic [SPD_W-1:0] SPD_MAX   = SPD_W'(SPEED_MAX);
`endif
  localparam logic [POS_W:0]   POS_LIM   = (POS_W + 1)'(POS_MAX_P);
  localparam logic [POS_W-1:0] POS_CLAMP = POS_W'(POS_MAX_P);
  localparam logic [POS_W-1:0] POS_RST   = POS_W'(POS_INIT);

  // Index 0 = up button, index 1 = down button.
  logic [1:0]              btn_s;
  logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]              stable_q, stable_d;

  motion_e                 state_q, state_d;
  logic [SPD_W-1:0]        speed_q, speed_d;
  logic [SPD_W-1:0]        speed_ramp_s;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [POS_W:0]          sum_s;
  cmd_e                    cmd_s;

  assign btn_s = {btn_down_sync, btn_up_sync};
  assign cmd_s = decode_cmd(stable_q[0], stable_q[1]);
  assign pos   = pos_q;

  // Debounce: the stable value flips only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]    = '0;
      stable_d[i] = stable_q[i];
      if (btn_s[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Speed used when the current move direction continues.
  always_comb begin
`ifdef PADDLE_ACCEL_EN
    if (speed_q >= SPD_MAX) begin
      speed_ramp_s = SPD_MAX;
    end else begin
      speed_ramp_s = speed_q + SPD_W'(1);
    end
`else
    speed_ramp_s = SPD_BASE;
`endif
  end

  // Motion FSM, speed and position next-state; everything holds between ticks.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    pos_d   = pos_q;
    sum_s   = '0;
    if (tick) begin
      case (cmd_s)
        CMD_UP: begin
          state_d = MOVE_UP;
          if (state_q == MOVE_UP) begin
            speed_d = speed_ramp_s;
          end else begin
            speed_d = SPD_BASE;
          end
          // Saturate at the top edge instead of wrapping below zero.
          if (pos_q < POS_W'(speed_d)) begin
            pos_d = '0;
          end else begin
            pos_d = pos_q - POS_W'(speed_d);
          end
        end
        CMD_DOWN: begin
          state_d = MOVE_DOWN;
          if (state_q == MOVE_DOWN) begin
            speed_d = speed_ramp_s;
          end else begin
            speed_d = SPD_BASE;
          end
          // One extra bit so the sum cannot overflow before the clamp.
          sum_s = {1'b0, pos_q} + (POS_W + 1)'(speed_d);
          if (sum_s > POS_LIM) begin
            pos_d = POS_CLAMP;
          end else begin
            pos_d = sum_s[POS_W-1:0];
          end
        end
        default: begin
          state_d = IDLE;
          speed_d = SPD_BASE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 2'b00;
      state_q  <= IDLE;
      speed_q  <= SPD_BASE;
      pos_q    <= POS_RST;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      state_q  <= state_d;
      speed_q  <= speed_d;
      pos_q    <= pos_d;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: turns four raw player buttons into per-frame paddle positions.
// Synchronises the buttons, detects the vsync assertion edge as the frame
// tick, and runs one paddle_axis per player. Build option PADDLE_ACCEL_EN
// enables the speed ramp inside paddle_axis.
// Ports:
//   clk          : pixel clock
//   reset        : asynchronous active-high reset
//   vsync        : vsync from the sync generator (already in clk domain)
//   p1_up/p1_down, p2_up/p2_down : raw asynchronous push-buttons
//   paddle1_next, paddle2_next   : registered paddle top lines, 0..POS_MAX
//   frame_tick   : one-clk pulse in the cycle the new positions appear
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H         = pong_pkg::SCREEN_H,
  parameter int PADDLE_HEIGHT    = pong_pkg::PADDLE_HEIGHT,
  parameter int POS_INIT         = 215,
  parameter int DEBOUNCE_CYCLES  = 65536,
  parameter int SPEED_BASE       = 2,
  parameter int SPEED_MAX        = 8,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             p1_up,
  input  logic             p1_down,
  input  logic             p2_up,
  input  logic             p2_down,
  output logic [POS_W-1:0] paddle1_next,
  output logic [POS_W-1:0] paddle2_next,
  output logic             frame_tick
);

  localparam int   POS_LIMIT  = SCREEN_H - PADDLE_HEIGHT;
  localparam logic VSYNC_IDLE = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Button bit order: {p2_down, p2_up, p1_down, p1_up}.
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic       vsync_q, vsync_d;
  logic       frame_tick_q, frame_tick_d;
  logic       tick_s;

  // Synchroniser inputs, vsync history and the assertion-edge tick.
  always_comb begin
    sync1_d      = {p2_down, p2_up, p1_down, p1_up};
    sync2_d      = sync1_q;
    vsync_d      = vsync;
    // Asserted now and not asserted last cycle; the deassertion edge is ignored.
    tick_s       = (vsync != VSYNC_IDLE) && (vsync_q == VSYNC_IDLE);
    frame_tick_d = tick_s;
  end

  // Synchronisers, vsync delay and frame_tick registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 4'b0000;
      sync2_q      <= 4'b0000;
      vsync_q      <= VSYNC_IDLE;
      frame_tick_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign frame_tick = frame_tick_q;

  paddle_axis #(
    .POS_INIT        (POS_INIT),
    .POS_MAX_P       (POS_LIMIT),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SPEED_BASE      (SPEED_BASE),
    .SPEED_MAX       (SPEED_MAX)
  ) u_axis_p1 (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick_s),
    .btn_up_sync   (sync2_q[0]),
    .btn_down_sync (sync2_q[1]),
    .pos           (paddle1_next)
  );

  paddle_axis #(
    .POS_INIT        (POS_INIT),
    .POS_MAX_P       (POS_LIMIT),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SPEED_BASE      (SPEED_BASE),
    .SPEED_MAX       (SPEED_MAX)
  ) u_axis_p2 (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick_s),
    .btn_up_sync   (sync2_q[2]),
    .btn_down_sync (sync2_q[3]),
    .pos           (paddle2_next)
  );

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed self-checking bench for paddle_ctrl with a short
// debounce (4 cycles). Expected speeds follow PADDLE_ACCEL_EN: ramped when
// defined, constant 2 otherwise.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic [9:0] paddle1_next, paddle2_next;
  logic       frame_tick;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  always #5 clk = ~clk;

  paddle_ctrl #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .p1_up        (p1_up),
    .p1_down      (p1_down),
    .p2_up        (p2_up),
    .p2_down      (p2_down),
    .paddle1_next (paddle1_next),
    .paddle2_next (paddle2_next),
    .frame_tick   (frame_tick)
  );

  // One frame: vsync asserted (low) 4 cycles, deasserted 3; counts frame_tick highs.
  task automatic do_frame(output int ft);
    ft = 0;
    @(negedge clk);
    vsync = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ft++;
    end
    vsync = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ft++;
    end
  endtask

  // Long enough for 2 sync stages plus 4 debounce cycles.
  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    vsync = 1'b1;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int ft;
    int ft_rst;
    repeat (2) @(negedge clk);
    n_cmp++; if (paddle1_next !== 10'd215) begin n_fail++; $display("FAIL reset_p1: got %0d want 215", paddle1_next); end
    n_cmp++; if (paddle2_next !== 10'd215) begin n_fail++; $display("FAIL reset_p2: got %0d want 215", paddle2_next); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_ft: got %b want 0", frame_tick); end
    reset = 1'b0;
    p1_up = 1'b1;
    settle();
    do_frame(ft);
    n_cmp++; if (paddle1_next !== 10'd213) begin n_fail++; $display("FAIL premove_p1: got %0d want 213", paddle1_next); end
    // Second tick, then reset while frame_tick is high and vsync is low.
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    n_cmp++; if (paddle1_next !== (ACCEL ? 10'd210 : 10'd211)) begin n_fail++; $display("FAIL premove2_p1: got %0d want %0d", paddle1_next, ACCEL ? 210 : 211); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (paddle1_next !== 10'd215) begin n_fail++; $display("FAIL midreset_p1: got %0d want 215", paddle1_next); end
    n_cmp++; if (paddle2_next !== 10'd215) begin n_fail++; $display("FAIL midreset_p2: got %0d want 215", paddle2_next); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL midreset_ft: got %b want 0", frame_tick); end
    p1_up = 1'b0;
    ft_rst = 0;
    repeat (6) begin
      @(negedge clk);
      vsync = ~vsync;
      @(negedge clk);
      if (frame_tick !== 1'b0) ft_rst++;
    end
    n_cmp++; if (ft_rst !== 0) begin n_fail++; $display("FAIL inreset_ft: got %0d pulses want 0", ft_rst); end
    vsync = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 3; f++) begin
      do_frame(ft);
      n_cmp++; if (ft !== 1) begin n_fail++; $display("FAIL postreset_ft[%0d]: got %0d want 1", f, ft); end
      n_cmp++; if (paddle1_next !== 10'd215) begin n_fail++; $display("FAIL postreset_p1[%0d]: got %0d want 215", f, paddle1_next); end
      n_cmp++; if (paddle2_next !== 10'd215) begin n_fail++; $display("FAIL postreset_p2[%0d]: got %0d want 215", f, paddle2_next); end
    end
  endtask

  task automatic test_p1_ramp();
    int ft;
    logic [9:0] exp_pos [3];
    if (ACCEL) begin
      exp_pos[0] = 10'd213; exp_pos[1] = 10'd210; exp_pos[2] = 10'd206;
    end else begin
      exp_pos[0] = 10'd213; exp_pos[1] = 10'd211; exp_pos[2] = 10'd209;
    end
    apply_reset();
    p1_up = 1'b1;
    settle();
    for (int f = 0; f < 3; f++) begin
      do_frame(ft);
      n_cmp++; if (paddle1_next !== exp_pos[f]) begin n_fail++; $display("FAIL ramp_p1[%0d]: got %0d want %0d", f, paddle1_next, exp_pos[f]); end
      n_cmp++; if (paddle2_next !== 10'd215) begin n_fail++; $display("FAIL ramp_p2[%0d]: got %0d want 215", f, paddle2_next); end
      n_cmp++; if (ft !== 1) begin n_fail++; $display("FAIL ramp_ft[%0d]: got %0d want 1", f, ft); end
    end
  endtask

  task automatic test_p1_floor();
    int ft;
    int prev;
    int max_step;
    apply_reset();
    p1_up = 1'b1;
    settle();
    prev = 215;
    max_step = 0;
    for (int f = 0; f < 120; f++) begin
      do_frame(ft);
      n_cmp++; if (int'(paddle1_next) > prev) begin n_fail++; $display("FAIL floor_mono[%0d]: got %0d after %0d", f, paddle1_next, prev); end
      if (prev - int'(paddle1_next) > max_step) max_step = prev - int'(paddle1_next);
      prev = int'(paddle1_next);
    end
    n_cmp++; if (paddle1_next !== 10'd0) begin n_fail++; $display("FAIL floor_p1: got %0d want 0", paddle1_next); end
    n_cmp++; if (max_step !== (ACCEL ? 8 : 2)) begin n_fail++; $display("FAIL floor_maxstep: got %0d want %0d", max_step, ACCEL ? 8 : 2); end
  endtask

  task automatic test_p2_ceiling();
    int ft;
    apply_reset();
    p2_down = 1'b1;
    settle();
    for (int f = 0; f < 120; f++) begin
      do_frame(ft);
      n_cmp++; if (paddle2_next > 10'd430) begin n_fail++; $display("FAIL ceil_range[%0d]: got %0d want <=430", f, paddle2_next); end
    end
    n_cmp++; if (paddle2_next !== 10'd430) begin n_fail++; $display("FAIL ceil_p2: got %0d want 430", paddle2_next); end
    n_cmp++; if (paddle1_next !== 10'd215) begin n_fail++; $display("FAIL ceil_p1: got %0d want 215", paddle1_next); end
    p2_down = 1'b0;
    p2_up = 1'b1;
    settle();
    do_frame(ft);
    n_cmp++; if (paddle2_next !== 10'd428) begin n_fail++; $display("FAIL reverse_p2: got %0d want 428", paddle2_next); end
  endtask

  task automatic test_both_buttons();
    int ft;
    apply_reset();
    p1_up = 1'b1;
    p1_down = 1'b1;
    settle();
    for (int f = 0; f < 3; f++) begin
      do_frame(ft);
      n_cmp++; if (paddle1_next !== 10'd215) begin n_fail++; $display("FAIL both_p1[%0d]: got %0d want 215", f, paddle1_next); end
    end
    p1_down = 1'b0;
    settle();
    do_frame(ft);
    n_cmp++; if (paddle1_next !== 10'd213) begin n_fail++; $display("FAIL release_p1: got %0d want 213", paddle1_next); end
    do_frame(ft);
    n_cmp++; if (paddle1_next !== (ACCEL ? 10'd210 : 10'd211)) begin n_fail++; $display("FAIL release2_p1: got %0d want %0d", paddle1_next, ACCEL ? 210 : 211); end
  endtask

  task automatic test_glitch();
    int ft;
    apply_reset();
    @(negedge clk);
    p2_up = 1'b1;
    repeat (3) @(negedge clk);
    p2_up = 1'b0;
    settle();
    do_frame(ft);
    n_cmp++; if (paddle2_next !== 10'd215) begin n_fail++; $display("FAIL glitch_p2: got %0d want 215", paddle2_next); end
  endtask

  task automatic test_vsync_deassert();
    int ft;
    apply_reset();
    p1_up = 1'b1;
    settle();
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    n_cmp++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL vs_assert_ft: got %b want 1", frame_tick); end
    n_cmp++; if (paddle1_next !== 10'd213) begin n_fail++; $display("FAIL vs_assert_p1: got %0d want 213", paddle1_next); end
    ft = 0;
    repeat (5) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ft++;
    end
    vsync = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ft++;
    end
    n_cmp++; if (ft !== 0) begin n_fail++; $display("FAIL vs_deassert_ft: got %0d pulses want 0", ft); end
    n_cmp++; if (paddle1_next !== 10'd213) begin n_fail++; $display("FAIL vs_deassert_p1: got %0d want 213", paddle1_next); end
  endtask

  initial begin
    reset = 1'b1;
    vsync = 1'b1;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    test_reset();
    test_p1_ramp();
    test_p1_floor();
    test_p2_ceiling();
    test_both_buttons();
    test_glitch();
    test_vsync_deassert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
